trisc_exec_ctrl: RTL and testbench



---
 rtl/trisc_exec_ctrl.sv | 122 ++++++++++++
 tb/tb_trisc_exec_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trisc_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : trisc_exec_ctrl
// Description : Sequencing stage ahead of the trisc 4-bit ALU. Accepts 9-bit
//               instructions over valid/ready, reads operands from a 4x4-bit
//               register file, drives the ALU, captures its result and writes
//               it back. Load-immediate bypasses the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module trisc_exec_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  input  logic [8:0] instr,
  output logic       instr_ready,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_s,
  input  logic [3:0] alu_r,
  output logic       wb_valid,
  output logic [1:0] wb_addr,
  output logic [3:0] wb_data,
  input  logic [1:0] dbg_addr,
  output logic [3:0] dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_CAPT = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t     r_state;
  logic [3:0] r_rf [4];
  logic [3:0] r_alu_a;
  logic [3:0] r_alu_b;
  logic [1:0] r_alu_s;
  logic [3:0] r_result;
  logic [1:0] r_rd;
  logic       r_wb_valid;

  // Instruction field decode
  logic       w_ldi;
  logic [1:0] w_op;
  logic [1:0] w_rd;
  logic [1:0] w_rs1;
  logic [1:0] w_rs2;
  logic [3:0] w_imm;

  assign w_ldi = instr[8];
  assign w_op  = instr[7:6];
  assign w_rd  = instr[5:4];
  assign w_rs1 = instr[3:2];
  assign w_rs2 = instr[1:0];
  assign w_imm = instr[3:0];

  // Ready only in IDLE and never while reset is held, independent of valid
  assign instr_ready = (r_state == S_IDLE) && !rst;

  assign alu_a    = r_alu_a;
  assign alu_b    = r_alu_b;
  assign alu_s    = r_alu_s;
  assign wb_valid = r_wb_valid;
  assign wb_addr  = r_rd;
  assign wb_data  = r_result;
  assign dbg_data = r_rf[dbg_addr];

  // Sequencer: accept, drive ALU, settle, capture, write back
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_alu_a    <= 4'd0;
      r_alu_b    <= 4'd0;
      r_alu_s    <= 2'd0;
      r_result   <= 4'd0;
      r_rd       <= 2'd0;
      r_wb_valid <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_rf[i] <= 4'd0;
      end
    end else begin
      r_wb_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_rd <= w_rd;
            if (w_ldi) begin
              // Immediate goes straight to the result; ALU drives are left alone
              r_result   <= w_imm;
              r_wb_valid <= 1'b1;
              r_state    <= S_WB;
            end else begin
              r_alu_a <= r_rf[w_rs1];
              r_alu_b <= r_rf[w_rs2];
              r_alu_s <= w_op;
              r_state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          // One cycle for the ALU combinational path to settle
          r_state <= S_CAPT;
        end
        S_CAPT: begin
          r_result   <= alu_r;
          r_wb_valid <= 1'b1;
          r_state    <= S_WB;
        end
        S_WB: begin
          r_rf[r_rd] <= r_result;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trisc_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_trisc_exec_ctrl
// Description : Scoreboard bench for trisc_exec_ctrl with a behavioural ALU
//               and register-file reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trisc_exec_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic [8:0] instr;
  logic       instr_ready;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_s;
  logic [3:0] alu_r;
  logic       wb_valid;
  logic [1:0] wb_addr;
  logic [3:0] wb_data;
  logic [1:0] dbg_addr;
  logic [3:0] dbg_data;

  trisc_exec_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_s       (alu_s),
    .alu_r       (alu_r),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int errs    = 0;

  typedef struct {
    logic [1:0] addr;
    logic [3:0] data;
    int         cyc;
    bit         alu;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] s;
  } exp_t;

  exp_t       sb [$];
  logic [3:0] m_rf [4];

  function automatic logic [3:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] s);
    case (s)
      2'd0:    return 4'((int'(a) + int'(b)) % 16);
      2'd1:    return 4'((int'(a) - int'(b) + 16) % 16);
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  // External ALU stand-in
  always_comb alu_r = alu_ref(alu_a, alu_b, alu_s);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic issue(input logic [8:0] v, input bit keep);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!instr_ready && n < 40) begin
      instr_valid = keep ? 1'b1 : 1'($urandom);
      instr       = 9'($urandom);
      n++;
      @(negedge clk);
    end
    if (!instr_ready) begin
      vectors++;
      errs++;
      $display("FAIL accept_timeout: instr_ready never rose within 40 cycles");
      instr_valid = 1'b0;
      return;
    end
    instr_valid = 1'b1;
    instr       = v;
    e.addr = v[5:4];
    e.alu  = !v[8];
    e.a    = m_rf[v[3:2]];
    e.b    = m_rf[v[1:0]];
    e.s    = v[7:6];
    e.data = v[8] ? v[3:0] : alu_ref(e.a, e.b, e.s);
    e.cyc  = cyc + (v[8] ? 1 : 3);
    sb.push_back(e);
    m_rf[e.addr] = e.data;
    @(posedge clk);
    #1;
    if (keep) begin
      instr_valid = 1'b1;
      instr       = 9'($urandom);
    end else begin
      instr_valid = 1'b0;
    end
    chk("ready_after_accept", 32'(instr_ready), 0);
  endtask

  task automatic settle();
    int n;
    n = 0;
    @(negedge clk);
    while (!instr_ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_rf();
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      chk($sformatf("rf_r%0d", i), 32'(dbg_data), 32'(m_rf[i]));
    end
  endtask

  task automatic model_reset();
    sb.delete();
    for (int i = 0; i < 4; i++) m_rf[i] = 4'd0;
  endtask

  // Monitor: pop and compare on every write-back pulse, then confirm the commit
  initial begin
    exp_t       e;
    bit         pend;
    bit         prev_wb;
    logic [1:0] pa;
    logic [3:0] pd;
    pend    = 0;
    prev_wb = 0;
    forever begin
      @(negedge clk);
      if (pend) begin
        dbg_addr = pa;
        #1;
        chk("dbg_after_wb", 32'(dbg_data), 32'(pd));
        pend = 0;
      end
      if (rst === 1'b1) begin
        prev_wb = 0;
        continue;
      end
      if (wb_valid === 1'b1) begin
        if (prev_wb) begin
          vectors++;
          errs++;
          $display("FAIL wb_back_to_back: wb_valid high in consecutive cycles at %0d", cyc);
        end
        if (sb.size() == 0) begin
          vectors++;
          errs++;
          $display("FAIL wb_spurious: wb_valid=1 addr=%0d data=%0d with no pending instruction",
                   wb_addr, wb_data);
        end else begin
          e = sb.pop_front();
          chk("wb_addr", 32'(wb_addr), 32'(e.addr));
          chk("wb_data", 32'(wb_data), 32'(e.data));
          chk("wb_cycle", 32'(cyc), 32'(e.cyc));
          if (e.alu) begin
            chk("alu_a", 32'(alu_a), 32'(e.a));
            chk("alu_b", 32'(alu_b), 32'(e.b));
            chk("alu_s", 32'(alu_s), 32'(e.s));
          end
          pend = 1;
          pa   = e.addr;
          pd   = e.data;
        end
      end
      prev_wb = (wb_valid === 1'b1);
    end
  end

  // Stimulus: directed scenarios, reset aborts, then randomized traffic
  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = 9'd0;
    dbg_addr    = 2'd0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("ready_in_reset", 32'(instr_ready), 0);
    chk("rst_alu_a", 32'(alu_a), 0);
    chk("rst_alu_b", 32'(alu_b), 0);
    chk("rst_alu_s", 32'(alu_s), 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_wb_addr", 32'(wb_addr), 0);
    chk("rst_wb_data", 32'(wb_data), 0);
    check_rf();
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 32'(instr_ready), 1);

    issue(9'b1_00_01_0101, 0);      // LDI r1 <- 5
    issue(9'b1_00_10_0011, 0);      // LDI r2 <- 3
    settle();
    check_rf();
    issue(9'b0_00_11_01_10, 0);     // ADD r3 = r1 + r2
    settle();
    dbg_addr = 2'd3;
    #1;
    chk("add_r3_is_8", 32'(dbg_data), 8);
    issue(9'b0_01_00_10_01, 0);     // SUB r0 = r2 - r1 (wraps)
    settle();
    dbg_addr = 2'd0;
    #1;
    chk("sub_r0_is_14", 32'(dbg_data), 14);
    issue(9'b0_10_00_01_10, 0);     // AND r0 = r1 & r2
    issue(9'b0_11_00_01_10, 0);     // XOR r0 = r1 ^ r2
    issue(9'b1_00_01_1001, 0);      // LDI r1 <- 9
    issue(9'b1_00_10_1001, 0);      // LDI r2 <- 9
    issue(9'b0_00_00_01_10, 0);     // ADD r0 = 9 + 9
    issue(9'b1_00_01_0101, 0);      // LDI r1 <- 5
    issue(9'b0_00_01_01_01, 0);     // ADD r1 = r1 + r1
    settle();
    check_rf();

    // Valid held high continuously across three queued instructions
    for (int i = 0; i < 3; i++) issue(9'($urandom), 1);
    settle();
    check_rf();

    // Reset during CAPT aborts the ALU op
    issue(9'b0_00_11_01_10, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    chk("ready_low_in_rst", 32'(instr_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_abort", 32'(instr_ready), 1);
    chk("wb_idle_after_abort", 32'(wb_valid), 0);
    settle();
    check_rf();

    // Reset during WB of an LDI suppresses the write
    issue(9'b1_00_10_0111, 0);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    settle();
    check_rf();

    for (int i = 0; i < 60; i++) issue(9'($urandom), 1'($urandom));
    settle();
    check_rf();
    chk("scoreboard_empty", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    errs++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
